// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
//
// Contents:
//   PC_XLEN, PC_MD_MAX_CYCLES, PC_PERF_W : default parameter values
//   pc_state_e                          : controller FSM state encoding
//   wdog_width()                        : counter width able to hold a cycle limit
package pipe_ctrl_pkg;

    localparam int unsigned PC_XLEN          = 32;
    localparam int unsigned PC_MD_MAX_CYCLES = 34;
    localparam int unsigned PC_PERF_W        = 32;

    // Encodings are fixed so that state values seen in waveforms match the
    // rest of the core's documentation.
    typedef enum logic [1:0] {
        PC_RUN  = 2'd0,
        PC_MDW  = 2'd1,
        PC_MEMW = 2'd2
    } pc_state_e;

    // Bits needed to count from 0 up to and including max_cycles.
    function automatic int unsigned wdog_width(input int unsigned max_cycles);
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running performance event counter.
//
// Counts cycles with en_i high, wraps modulo 2^W, synchronous clear.
//
// Ports:
//   clk_i  in   1  clock
//   clr_i  in   1  synchronous clear (wins over en_i)
//   en_i   in   1  count this cycle
//   cnt_o  out  W  current count (registered)
module pipe_perf_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard / sequencing controller for the 5-stage rv32im pipeline.
//
// Collects load-use, branch redirect, multi-cycle mul/div and data-bus wait
// requests and turns them into per-stage stall/flush strobes plus the PC
// redirect. Strobes are combinational from the registered FSM state and the
// current inputs; while rst_n_i is low every output is forced to 0.
//
// Optional feature: define PIPE_CTRL_PERF_EN to add three PERF_W-bit
// performance counters (stall cycles, redirects, load-use bubbles).
//
// Ports:
//   clk_i             in   1       clock
//   rst_n_i           in   1       synchronous active-low reset
//   loaduse_hazard_i  in   1       ID instruction needs the load result in EX
//   branch_taken_i    in   1       taken branch / JAL / JALR in EX
//   branch_target_i   in   XLEN    redirect address
//   md_start_i        in   1       mul/div issued (pulse)
//   md_done_i         in   1       mul/div result valid (pulse)
//   mem_busy_i        in   1       data bus has not accepted the access (level)
//   stall_if_o        out  1       hold PC and IF/ID
//   stall_id_o        out  1       hold ID/EX
//   stall_ex_o        out  1       hold EX/MEM
//   flush_id_o        out  1       clear IF/ID
//   flush_ex_o        out  1       clear ID/EX
//   pc_redirect_o     out  1       fetch loads pc_target_o
//   pc_target_o       out  XLEN    redirect address, 0 when no redirect
//   perf_stall_cnt_o  out  PERF_W  cycles with stall_if_o=1   (PIPE_CTRL_PERF_EN)
//   perf_flush_cnt_o  out  PERF_W  redirects                  (PIPE_CTRL_PERF_EN)
//   perf_lu_cnt_o     out  PERF_W  load-use bubbles           (PIPE_CTRL_PERF_EN)
//   md_timeout_o      out  1       mul/div watchdog expired (pulse)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned XLEN          = PC_XLEN,
    parameter int unsigned MD_MAX_CYCLES = PC_MD_MAX_CYCLES,
    parameter int unsigned PERF_W        = PC_PERF_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              loaduse_hazard_i,
    input  logic              branch_taken_i,
    input  logic [XLEN-1:0]   branch_target_i,
    input  logic              md_start_i,
    input  logic              md_done_i,
    input  logic              mem_busy_i,
    output logic              stall_if_o,
    output logic              stall_id_o,
    output logic              stall_ex_o,
    output logic              flush_id_o,
    output logic              flush_ex_o,
    output logic              pc_redirect_o,
    output logic [XLEN-1:0]   pc_target_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [PERF_W-1:0] perf_stall_cnt_o,
    output logic [PERF_W-1:0] perf_flush_cnt_o,
    output logic [PERF_W-1:0] perf_lu_cnt_o,
`endif
    output logic              md_timeout_o
);

    localparam int unsigned WdogW = wdog_width(MD_MAX_CYCLES);

    pc_state_e        state_q, state_d;
    logic [WdogW-1:0] wdog_q, wdog_d;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= PC_RUN;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        wdog_d        = wdog_q;
        stall_if_o    = 1'b0;
        stall_id_o    = 1'b0;
        stall_ex_o    = 1'b0;
        flush_id_o    = 1'b0;
        flush_ex_o    = 1'b0;
        pc_redirect_o = 1'b0;
        pc_target_o   = '0;
        md_timeout_o  = 1'b0;

        unique case (state_q)
            PC_RUN: begin
                if (mem_busy_i) begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    stall_ex_o = 1'b1;
                    state_d    = PC_MEMW;
                end else if (md_start_i) begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    stall_ex_o = 1'b1;
                    wdog_d     = WdogW'(1);
                    state_d    = PC_MDW;
                end else if (branch_taken_i) begin
                    // The load-use instruction in ID is flushed, so its
                    // hazard needs no bubble.
                    pc_redirect_o = 1'b1;
                    pc_target_o   = branch_target_i;
                    flush_id_o    = 1'b1;
                    flush_ex_o    = 1'b1;
                end else if (loaduse_hazard_i) begin
                    stall_if_o = 1'b1;
                    flush_ex_o = 1'b1;
                end
            end

            PC_MDW: begin
                // EX is frozen, so branch and load-use requests are stale.
                wdog_d = wdog_q + WdogW'(1);
                if (md_done_i) begin
                    state_d = mem_busy_i ? PC_MEMW : PC_RUN;
                end else if (wdog_q == WdogW'(MD_MAX_CYCLES)) begin
                    md_timeout_o = 1'b1;
                    state_d      = PC_RUN;
                end else begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    stall_ex_o = 1'b1;
                end
            end

            PC_MEMW: begin
                if (mem_busy_i) begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    stall_ex_o = 1'b1;
                end else begin
                    // Release cycle: the instruction held in EX moves on now,
                    // so a redirect or load-use it raises must be honoured
                    // this cycle or it is lost. A new mul/div start is not
                    // accepted here.
                    state_d = PC_RUN;
                    if (branch_taken_i) begin
                        pc_redirect_o = 1'b1;
                        pc_target_o   = branch_target_i;
                        flush_id_o    = 1'b1;
                        flush_ex_o    = 1'b1;
                    end else if (loaduse_hazard_i) begin
                        stall_if_o = 1'b1;
                        flush_ex_o = 1'b1;
                    end
                end
            end

            default: begin
                state_d = PC_RUN;
            end
        endcase

        // Outputs are quiet for the whole reset cycle, whatever the inputs.
        if (!rst_n_i) begin
            state_d       = PC_RUN;
            wdog_d        = '0;
            stall_if_o    = 1'b0;
            stall_id_o    = 1'b0;
            stall_ex_o    = 1'b0;
            flush_id_o    = 1'b0;
            flush_ex_o    = 1'b0;
            pc_redirect_o = 1'b0;
            pc_target_o   = '0;
            md_timeout_o  = 1'b0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    // A load-use bubble is the only case that stalls IF without holding ID/EX.
    logic lu_bubble;
    assign lu_bubble = stall_if_o & flush_ex_o & ~stall_id_o;

    pipe_perf_cnt #(
        .W (PERF_W)
    ) u_perf_stall (
        .clk_i (clk_i),
        .clr_i (~rst_n_i),
        .en_i  (stall_if_o),
        .cnt_o (perf_stall_cnt_o)
    );

    pipe_perf_cnt #(
        .W (PERF_W)
    ) u_perf_flush (
        .clk_i (clk_i),
        .clr_i (~rst_n_i),
        .en_i  (pc_redirect_o),
        .cnt_o (perf_flush_cnt_o)
    );

    pipe_perf_cnt #(
        .W (PERF_W)
    ) u_perf_lu (
        .clk_i (clk_i),
        .clr_i (~rst_n_i),
        .en_i  (lu_bubble),
        .cnt_o (perf_lu_cnt_o)
    );
`endif

endmodule
